// File: rtl/matrix_operand_loader_if.sv
// Operand byte stream into the matrix operand loader.
// The master drives data/valid and the slave returns ready.
interface matrix_operand_loader_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/matrix_operand_loader.sv
// Assembles matrices A then B (row-major) from a byte stream, launches the subtractor
// and blocks further input until the subtractor's sticky done rises.
module matrix_operand_loader #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N      = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  matrix_operand_loader_if.slave                 in_if,
  input  logic                                   flush,
  output logic [0:N-1][0:N-1][DATA_W-1:0]        a_out,
  output logic [0:N-1][0:N-1][DATA_W-1:0]        b_out,
  output logic                                   start,
  input  logic                                   sub_done,
  output logic                                   busy,
  output logic [$clog2(2*N*N):0]                 load_count
);

  localparam int unsigned Elems = N * N;
  localparam int unsigned IdxW  = $clog2(Elems);
  localparam int unsigned RowW  = $clog2(N);
  localparam int unsigned CntW  = $clog2(2 * Elems) + 1;

  typedef enum logic [1:0] {StLoadA, StLoadB, StLaunch, StWait} state_e;

  state_e                              state_q, state_d;
  logic [IdxW-1:0]                     idx_q, idx_d;
  logic [CntW-1:0]                     cnt_q, cnt_d;
  logic [0:N-1][0:N-1][DATA_W-1:0]     a_q, a_d, b_q, b_d;
  logic                                busy_q, busy_d;
  logic                                done_q;
  logic                                ready;
  logic [RowW-1:0]                     row, col;

  assign row = RowW'(idx_q / IdxW'(N));
  assign col = RowW'(idx_q % IdxW'(N));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    ready   = 1'b0;
    start   = 1'b0;
    unique case (state_q)
      StLoadA, StLoadB: begin
        ready = 1'b1;
        // Flush wins over a coincident transfer; array contents are kept.
        if (flush) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = StLoadA;
        end else if (in_if.in_valid) begin
          if (state_q == StLoadA) a_d[row][col] = in_if.in_data;
          else                    b_d[row][col] = in_if.in_data;
          cnt_d = cnt_q + CntW'(1);
          if (idx_q == IdxW'(Elems - 1)) begin
            idx_d   = '0;
            state_d = (state_q == StLoadA) ? StLoadB : StLaunch;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StLaunch: begin
        start   = 1'b1;
        busy_d  = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        // Only a fresh 0->1 edge counts; a level left over from the last job is ignored.
        if (sub_done && !done_q) begin
          busy_d  = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StLoadA;
        end
      end
      default: state_d = StLoadA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StLoadA;
      idx_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= sub_done;
    end
  end

  assign in_if.in_ready = ready && rst_n;
  assign a_out          = a_q;
  assign b_out          = b_q;
  assign busy           = busy_q;
  assign load_count     = cnt_q;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Randomized bench for matrix_operand_loader against a frame-level reference model.
module tb_matrix_operand_loader;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned N      = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic start;
  logic sub_done;
  logic busy;
  logic [5:0] load_count;
  logic [0:N-1][0:N-1][DATA_W-1:0] a_out, b_out;

  matrix_operand_loader_if #(.DATA_W(DATA_W)) bus ();

  matrix_operand_loader #(.DATA_W(DATA_W), .N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (bus),
    .flush      (flush),
    .a_out      (a_out),
    .b_out      (b_out),
    .start      (start),
    .sub_done   (sub_done),
    .busy       (busy),
    .load_count (load_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: elements accepted in the frame, launch pending, waiting on done.
  int        m_n = 0;
  bit        m_launch = 1'b0;
  bit        m_wait = 1'b0;
  bit        m_prev_done = 1'b0;
  logic [7:0] m_a [16];
  logic [7:0] m_b [16];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return !m_launch && !m_wait;
  endfunction

  task automatic cycle(input bit v, input logic [7:0] d, input bit f, input bit sd,
                       input bit rn);
    bus.in_valid = v;
    bus.in_data  = d;
    flush        = f;
    sub_done     = sd;
    rst_n        = rn;
    #1;
    check_eq("in_ready", 32'(bus.in_ready), 32'(rn && m_ready()));
    if (!rn) begin
      m_n = 0; m_launch = 0; m_wait = 0; m_prev_done = 0;
      for (int i = 0; i < 16; i++) begin m_a[i] = '0; m_b[i] = '0; end
    end else begin
      if (m_wait) begin
        if (sd && !m_prev_done) begin m_wait = 0; m_n = 0; end
      end else if (m_launch) begin
        m_launch = 0; m_wait = 1;
      end else if (f) begin
        m_n = 0;
      end else if (v) begin
        if (m_n < 16) m_a[m_n] = d;
        else          m_b[m_n-16] = d;
        m_n++;
        if (m_n == 32) m_launch = 1;
      end
      m_prev_done = sd;
    end
    @(posedge clk);
    #1;
    check_eq("start", 32'(start), 32'(m_launch));
    check_eq("busy", 32'(busy), 32'(m_wait));
    check_eq("load_count", 32'(load_count), 32'(m_n));
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("a_out[%0d][%0d]", i / 4, i % 4), 32'(a_out[i/4][i%4]), 32'(m_a[i]));
      check_eq($sformatf("b_out[%0d][%0d]", i / 4, i % 4), 32'(b_out[i/4][i%4]), 32'(m_b[i]));
    end
  endtask

  // Push count bytes with random valid gaps; seq selects 0,1,2.. data instead of random.
  task automatic feed(input int count, input int gap_pct, input bit seq, input bit sd);
    int sent;
    int guard;
    bit v;
    logic [7:0] d;
    sent = 0;
    guard = 0;
    while (sent < count && guard < 1000) begin
      d = seq ? 8'(sent) : 8'($urandom);
      v = ($urandom_range(99) >= 32'(gap_pct));
      if (v && m_ready()) sent++;
      cycle(v, d, 1'b0, sd, 1'b1);
      guard++;
    end
    check_eq("feed_complete", 32'(sent), 32'(count));
  endtask

  task automatic idle(input int n, input bit f, input bit sd);
    for (int i = 0; i < n; i++) cycle(1'($urandom), 8'($urandom), f, sd, 1'b1);
  endtask

  initial begin
    bus.in_valid = 0; bus.in_data = '0; flush = 0; sub_done = 0; rst_n = 0;
    for (int i = 0; i < 16; i++) begin m_a[i] = '0; m_b[i] = '0; end
    #2;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);

    // Back-to-back 0x00..0x1F, then a long wait before done rises.
    feed(32, 0, 1'b1, 1'b0);
    idle(20, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

    // Random gaps while done stays high from the previous job: stale level.
    feed(32, 40, 1'b0, 1'b1);
    idle(6, 1'b0, 1'b1);
    idle(2, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b1);
    idle(2, 1'b0, 1'b1);

    // Flush after 10 bytes with a coincident valid byte.
    feed(10, 20, 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b1, 1'b0, 1'b1);
    feed(32, 20, 1'b0, 1'b0);

    // Flush during WAIT has no effect.
    idle(6, 1'b1, 1'b0);
    idle(2, 1'b1, 1'b1);
    idle(2, 1'b0, 1'b0);

    // Reset mid-LOAD_B at idx 7.
    feed(23, 30, 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    feed(5, 0, 1'b0, 1'b0);
    feed(27, 25, 1'b0, 1'b0);
    idle(3, 1'b0, 1'b0);
    idle(2, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
